// File: rtl/cpu_pkg.sv
// Shared types for the load/store unit: RV32I access widths and LSU FSM states.
package cpu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction
// and extension, plus misaligned/illegal access detection.
module lsu_align
    import cpu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{off, 3'b000} +: 8];
    assign half_v = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        err       = 1'b0;
        case (mem_width_t'(funct3))
            LB: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_v[7]}}, byte_v};
            end
            LBU: begin
                err       = we;
                be        = 4'b0001 << off;
                rdata_ext = {24'd0, byte_v};
            end
            LH: begin
                err       = off[0];
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_v[15]}}, half_v};
            end
            LHU: begin
                err       = we | off[0];
                be        = 4'b0011 << off;
                rdata_ext = {16'd0, half_v};
            end
            LW: begin
                err       = (off != 2'b00);
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one request at a time over a req/gnt/rvalid memory port.
// Define LSU_TIMEOUT_EN to bound the wait for mem_rvalid by TIMEOUT_CYCLES.
module lsu
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    lsu_state_t  state_q, state_d;
    logic        we_q, err_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q, wdata_q, data_q;
    logic [3:0]  be_q;
    logic [4:0]  rd_q;

    logic        idle, accept, expire;
    logic        a_we, a_err;
    logic [2:0]  a_funct3;
    logic [1:0]  a_off;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;

    assign idle   = (state_q == IDLE);
    assign accept = idle & req_valid;

    // One aligner serves both decode at accept and extraction in WAIT.
    assign a_we     = idle ? req_we        : we_q;
    assign a_funct3 = idle ? req_funct3    : funct3_q;
    assign a_off    = idle ? req_addr[1:0] : off_q;

    lsu_align u_align (
        .we        (a_we),
        .funct3    (a_funct3),
        .off       (a_off),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (a_be),
        .wdata_rep (a_wdata),
        .rdata_ext (a_rdata),
        .err       (a_err)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt_q <= '0;
        else if (state_q == REQ)  cnt_q <= '0;
        else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
    end

    assign expire = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = a_err ? RESP : REQ;
            REQ:     if (mem_gnt) state_d = we_q ? RESP : WAIT;
            WAIT:    if (mem_rvalid || expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                off_q    <= req_addr[1:0];
                addr_q   <= {req_addr[31:2], 2'b00};
                be_q     <= a_be;
                wdata_q  <= a_wdata;
                rd_q     <= (req_we || a_err) ? '0 : req_rd;
                err_q    <= a_err;
                data_q   <= '0;
            end
            // rvalid in the expiry cycle takes priority over the timeout.
            if (state_q == WAIT) begin
                if (mem_rvalid) begin
                    data_q <= a_rdata;
                end else if (expire) begin
                    err_q <= 1'b1;
                    rd_q  <= '0;
                end
            end
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        mem_req   = (state_q == REQ);
        mem_we    = (state_q == REQ) & we_q;
        rsp_valid = (state_q == RESP);
    end

    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rsp_rd    = rd_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases then randomized ops against a word-array memory model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rd     (rsp_rd),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        int   size;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        return !legal || ((int'(off) % size) != 0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] s;
        s = word >> (8 * int'(off));
        case (f3)
            3'd0:    return int'($signed(s[7:0]));
            3'd1:    return int'($signed(s[15:0]));
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return word;
        endcase
    endfunction

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int gnt_dly, input int rv_dly);
        logic        err;
        logic [3:0]  be;
        logic [31:0] wrep, exp_data;
        int          idx;
        err  = ref_err(we, f3, addr[1:0]);
        be   = ref_be(f3, addr[1:0]);
        wrep = ref_wdata(f3, wdata);
        idx  = int'(addr[5:2]);
        check("ready_before", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        step();
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        if (err) begin
            check("err_no_req", mem_req, 0);
            check("err_valid", rsp_valid, 1);
            check("err_flag", rsp_err, 1);
            check("err_rd", rsp_rd, 0);
            check("err_data", rsp_data, 0);
            step();
            check("err_done", {rsp_valid, req_ready}, 2'b01);
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            check("req_mem_req", mem_req, 1);
            check("req_not_ready", req_ready, 0);
            check("req_addr", mem_addr, {addr[31:2], 2'b00});
            check("req_be", mem_be, be);
            check("req_we", mem_we, we);
            if (we) check("req_wdata", mem_wdata, wrep);
            mem_gnt    = (i == gnt_dly);
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            step();
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (we) begin
            check("st_valid", rsp_valid, 1);
            check("st_err", rsp_err, 0);
            check("st_rd", rsp_rd, 0);
            check("st_data", rsp_data, 0);
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] = wrep[8*b +: 8];
            step();
            check("st_done", {rsp_valid, req_ready}, 2'b01);
        end else begin
            exp_data = ref_load(mem[idx], f3, addr[1:0]);
            for (int i = 0; i <= rv_dly; i++) begin
                check("wait_quiet", {mem_req, rsp_valid, req_ready}, 3'b000);
                mem_gnt    = 1'($urandom);
                mem_rvalid = (i == rv_dly);
                mem_rdata  = mem_rvalid ? mem[idx] : $urandom;
                step();
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            check("ld_valid", rsp_valid, 1);
            check("ld_err", rsp_err, 0);
            check("ld_rd", rsp_rd, rd);
            check("ld_data", rsp_data, exp_data);
            step();
            check("ld_done", {rsp_valid, req_ready}, 2'b01);
        end
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        step();
        step();
        check("rst_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp_rd", rsp_rd, 0);
        check("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        step();

        mem[0] = 32'hDEADBEEF;
        do_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 0, 0);
        mem[0] = 32'h80FF_FFFF;
        do_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 0, 0);
        do_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1, 2);
        do_op(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd9, 0, 0);
        do_op(1'b0, 3'b001, 32'h0000_0202, 32'h0, 5'd10, 0, 1);
        do_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd11, 0, 0);
        do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd12, 0, 0);
        do_op(1'b1, 3'b100, 32'h0000_0100, 32'h55, 5'd13, 0, 0);
        do_op(1'b1, 3'b000, 32'h0000_0311, 32'h0000_00A5, 5'd14, 5, 0);
        do_op(1'b0, 3'b010, 32'h0000_0108, 32'h0, 5'd15, 5, 0);

        // reset while waiting for rvalid abandons the load
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104; req_rd = 5'd7;
        step();
        req_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("rstw_in_wait", {mem_req, rsp_valid, req_ready}, 3'b000);
        #2 rst = 1'b1;
        #1;
        check("rstw_mem_req", mem_req, 0);
        check("rstw_ready", req_ready, 1);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstw_no_rsp", rsp_valid, 0);
            step();
        end

`ifdef LSU_TIMEOUT_EN
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h108; req_rd = 5'd3;
        step();
        req_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_waiting", rsp_valid, 0);
            step();
        end
        check("to_valid", rsp_valid, 1);
        check("to_err", rsp_err, 1);
        check("to_data", rsp_data, 0);
        check("to_rd", rsp_rd, 0);
        step();
        do_op(1'b0, 3'b010, 32'h0000_010C, 32'h0, 5'd4, 0, 3);
`endif

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd4;
                else if (f3 == 3'd4) f3 = 3'd5;
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) addr[0] = 1'b0;
                if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            end
            do_op(we, f3, addr, $urandom, 5'($urandom_range(1, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the integer ALU in the execute/memory boundary. It consumes the ALU sum (rs1 + imm) as the effective address, performs one RV32I load or store per request over a request/grant/rvalid data-memory port, and returns sign/zero-extended load data with the destination register index for writeback. Misaligned or illegal accesses never reach memory; they are reported as errors.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles waited for `mem_rvalid` after grant; used only when `LSU_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a memory op.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width field: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- `req_addr`  in  32  effective address from the ALU result.
- `req_wdata`  in  32  store data (rs2).
- `req_rd`  in  5  load destination register.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  word-aligned address, {req_addr[31:2], 2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  memory accepts request this cycle.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  32  load data word.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rd`  out  5  destination register; 0 for stores and errors.
- `rsp_data`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned, illegal funct3, or timeout.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields and decode:
  - illegal (load funct3 011/110/111; store funct3 ≥ 011) or misaligned (H with addr[0]=1, W with addr[1:0]≠0) → RESP, `rsp_err`=1, no memory access.
  - otherwise → REQ.
- REQ: `mem_req`=1, address/be/wdata/we held stable until `mem_gnt`. On grant: store → RESP; load → WAIT.
- WAIT: on `mem_rvalid`, capture extracted data → RESP.
- RESP: `rsp_valid`=1 for exactly one cycle → IDLE.
- Byte lane off = addr[1:0]. Stores: SB `mem_be`=4'b0001<<off, data {4{wdata[7:0]}}; SH 4'b0011<<off (off ∈ {0,2}), {2{wdata[15:0]}}; SW 4'b1111. Loads: `mem_be`=same pattern, `mem_we`=0.
- Load extract: B/BU = rdata[8*off +: 8], H/HU = rdata[16*addr[1] +: 16]; B/H sign-extend, BU/HU/W zero-extend.
- `mem_rvalid` outside WAIT and `mem_gnt` outside REQ are ignored.

## Timing
- Reset: state IDLE; `req_ready`=1; `mem_req`, `mem_we`, `rsp_valid`, `rsp_err`=0; `mem_addr`, `mem_be`, `mem_wdata`, `rsp_rd`, `rsp_data`=0.
- Memory protocol: `mem_rvalid` arrives no earlier than the cycle after `mem_gnt`.
- Minimum load: accept cycle 0, `mem_req` cycle 1 with grant, `mem_rvalid` cycle 2, `rsp_valid` cycle 3, `req_ready` cycle 4.
- Minimum store: accept cycle 0, `mem_req`+grant cycle 1, `rsp_valid` cycle 2.
- Error response: `rsp_valid` in cycle 1 after accept.
- Outputs are registered or decoded from state only; there are no combinational paths from `mem_*` inputs to `rsp_*`.
- Reset asserted mid-transaction: the transaction is abandoned, `mem_req` drops immediately, and no response is produced.

## Configuration
- `LSU_TIMEOUT_EN` defined: an 8-bit ($clog2(TIMEOUT_CYCLES+1)) counter clears on entering WAIT and increments each cycle in WAIT. When it reaches `TIMEOUT_CYCLES` without `mem_rvalid`, go to RESP with `rsp_err`=1, `rsp_data`=0. `mem_rvalid` in the same cycle as expiry wins.
- Not defined: no counter; WAIT holds indefinitely.

## Structure
- `cpu_pkg`: `mem_width_t` enum for funct3 widths (LB/LH/LW/LBU/LHU) and the `lsu_state_t` enum.
- Sub-module `lsu_align`: purely combinational; generates byte enables and replicated write data, extracts and extends load data, and flags misaligned or illegal accesses. The FSM lives in `lsu`.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, grant immediate, rvalid next cycle → `mem_be`=1111, `rsp_data`=0xDEADBEEF, `rsp_valid` 3 cycles after accept.
- LB addr 0x103, rdata 0x80FF_FFFF → `rsp_data`=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD → `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `rsp_rd`=0.
- LW addr 0x101 → no `mem_req`, `rsp_err`=1 one cycle after accept; load funct3 011 → same.
- Grant withheld 5 cycles → `mem_*` outputs stable throughout, `req_ready`=0; reset asserted in WAIT → `mem_req`=0, no `rsp_valid`.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4 and no rvalid → `rsp_err`=1 after 4 WAIT cycles; rvalid arriving exactly at expiry → normal data, `rsp_err`=0.
